exp_renormalizer: RTL and testbench

- Return path of the exponent-alignment stage in the GEMM datapath.
- Takes the signed sum of aligned significands plus the shared max exponent, and re-normalises the result into sign/exponent/mantissa format.
- Works by leading-one detection, mantissa shift, exponent adjust, and overflow/underflow handling.
- Two-stage pipeline with valid/ready handshakes on both sides; sits between the significand adder tree and the result packer.

---
 rtl/exp_renormalizer_pkg.sv | 31 +++
 rtl/exp_renormalizer_if.sv | 29 ++
 rtl/exp_renormalizer_lead_one_detect.sv | 17 +
 rtl/exp_renormalizer.sv | 124 ++++++++++++
 tb/tb_exp_renormalizer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/exp_renormalizer_pkg.sv
// Shared widths, derived constants and pipeline payload types for the
// exponent renormalizer on the GEMM return path.
package exp_renormalizer_pkg;

  localparam int expWidth = 4;
  localparam int sigWidth = 3;
  localparam int sumWidth = 8;

  localparam int lzcWidth       = $clog2(sumWidth);
  localparam int EXP_MAX_FINITE = (1 << expWidth) - 2;
  localparam int EXP_SAT        = (1 << expWidth) - 1;
  // Two guard bits let max_exp + P - sigWidth go negative or past EXP_SAT.
  localparam int EADJ_W         = expWidth + 2;

  typedef struct packed {
    logic                sign;
    logic [sumWidth-1:0] mag;
    logic [lzcWidth-1:0] pos;
    logic                zero;
    logic [expWidth-1:0] max_exp;
  } s1_payload_t;

  typedef struct packed {
    logic                sign;
    logic [expWidth-1:0] exponent;
    logic [sigWidth-1:0] mant;
    logic                ovf;
    logic                unf;
  } result_t;

endpackage

// File: rtl/exp_renormalizer_if.sv
// Input (sum + shared exponent) and output (sign/exp/mant + flags) streams
// of the renormalizer, each with its own valid/ready pair.
interface exp_renormalizer_if;
  import exp_renormalizer_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic [expWidth-1:0]        in_max_exp;
  logic signed [sumWidth-1:0] in_sum;

  logic                       out_valid;
  logic                       out_ready;
  logic                       out_sign;
  logic [expWidth-1:0]        out_exp;
  logic [sigWidth-1:0]        out_mant;
  logic                       out_ovf;
  logic                       out_unf;

  modport master (
    output in_valid, in_max_exp, in_sum, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_max_exp, in_sum, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant, out_ovf, out_unf
  );

endinterface

// File: rtl/exp_renormalizer_lead_one_detect.sv
// Priority encoder: position of the most significant set bit of mag
// (0 when mag is zero; the zero case is flagged separately).
module exp_renormalizer_lead_one_detect
  import exp_renormalizer_pkg::*;
(
  input  logic [sumWidth-1:0] mag,
  output logic [lzcWidth-1:0] pos
);

  always_comb begin
    pos = '0;
    for (int i = 0; i < sumWidth; i++) begin
      if (mag[i]) pos = lzcWidth'(i);
    end
  end

endmodule

// File: rtl/exp_renormalizer.sv
// Renormalizes a signed aligned significand sum plus shared exponent into
// sign/exponent/mantissa form over a two-stage valid/ready pipeline.
module exp_renormalizer
  import exp_renormalizer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  exp_renormalizer_if.slave bus
);

  localparam logic signed [EADJ_W-1:0] E_SAT = EADJ_W'(EXP_SAT);

  function automatic logic [sigWidth-1:0] shift_mant(
    input logic [sumWidth-1:0] mag,
    input logic [lzcWidth-1:0] pos
  );
    logic [sumWidth-1:0] sh;
    // Right shift truncates the bits below the mantissa (round toward zero).
    if (pos > lzcWidth'(sigWidth)) sh = mag >> (pos - lzcWidth'(sigWidth));
    else                           sh = mag << (lzcWidth'(sigWidth) - pos);
    return sh[sigWidth-1:0];
  endfunction

  function automatic logic signed [EADJ_W-1:0] adjust_exp(
    input logic [expWidth-1:0] max_exp,
    input logic [lzcWidth-1:0] pos
  );
    logic signed [EADJ_W-1:0] me;
    logic signed [EADJ_W-1:0] p;
    me = $signed({{(EADJ_W-expWidth){1'b0}}, max_exp});
    p  = $signed({{(EADJ_W-lzcWidth){1'b0}}, pos});
    return me + p - EADJ_W'(sigWidth);
  endfunction

  function automatic result_t saturate(
    input logic                     sign,
    input logic                     zero,
    input logic signed [EADJ_W-1:0] e,
    input logic [sigWidth-1:0]      mant
  );
    result_t r;
    r = '0;
    if (zero) begin
      r = '0;
    end else if (e[EADJ_W-1] || (e == '0)) begin
      r.unf = 1'b1;
    end else if (e >= E_SAT) begin
      r.sign     = sign;
      r.exponent = expWidth'(EXP_MAX_FINITE);
      r.mant     = '1;
      r.ovf      = 1'b1;
    end else begin
      r.sign     = sign;
      r.exponent = e[expWidth-1:0];
      r.mant     = mant;
    end
    return r;
  endfunction

  logic                vld_p1;
  s1_payload_t         pay_p1;
  logic                vld_p2;
  result_t             res_p2;
  logic                s1_advance;
  logic                in_ready;

  logic                sign_p0;
  logic [sumWidth-1:0] sum_u_p0;
  logic [sumWidth-1:0] mag_p0;
  logic [lzcWidth-1:0] pos_p0;

  assign s1_advance   = !vld_p2 || bus.out_ready;
  assign in_ready     = !vld_p1 || s1_advance;
  assign bus.in_ready = in_ready;

  // Stage 0 -> 1: magnitude and leading-one position
  assign sign_p0  = bus.in_sum[sumWidth-1];
  assign sum_u_p0 = bus.in_sum;
  // Unsigned magnitude keeps -2^(sumWidth-1) exact as 1 followed by zeros.
  assign mag_p0   = sign_p0 ? (~sum_u_p0 + sumWidth'(1)) : sum_u_p0;

  exp_renormalizer_lead_one_detect u_lod (
    .mag (mag_p0),
    .pos (pos_p0)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)        vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_ready && bus.in_valid) begin
      pay_p1.sign    <= sign_p0;
      pay_p1.mag     <= mag_p0;
      pay_p1.pos     <= pos_p0;
      pay_p1.zero    <= (mag_p0 == '0);
      pay_p1.max_exp <= bus.in_max_exp;
    end
  end

  // Stage 1 -> 2: shift, exponent adjust, saturation into the output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
    end else if (s1_advance) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        res_p2 <= saturate(pay_p1.sign, pay_p1.zero,
                           adjust_exp(pay_p1.max_exp, pay_p1.pos),
                           shift_mant(pay_p1.mag, pay_p1.pos));
      end
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_sign  = res_p2.sign;
  assign bus.out_exp   = res_p2.exponent;
  assign bus.out_mant  = res_p2.mant;
  assign bus.out_ovf   = res_p2.ovf;
  assign bus.out_unf   = res_p2.unf;

endmodule

// File: tb/tb_exp_renormalizer.sv
// Scoreboard bench for exp_renormalizer: directed vectors with hand-computed
// results, backpressure and mid-operation reset.
module tb_exp_renormalizer;

  typedef struct packed {
    logic       sign;
    logic [3:0] ex;
    logic [2:0] m;
    logic       ovf;
    logic       unf;
  } res_t;

  typedef struct {
    logic [3:0]        me;
    logic signed [7:0] sum;
    res_t              res;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  bit   sender_done;
  res_t sb[$];

  exp_renormalizer_if bus ();

  exp_renormalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic res_t mk(input logic s, input int e, input int m,
                              input logic o, input logic u);
    res_t r;
    r.sign = s; r.ex = 4'(e); r.m = 3'(m); r.ovf = o; r.unf = u;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare presented output with scoreboard head; pop on transfer.
  always @(negedge clk) begin
    res_t got;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      got = {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_ovf, bus.out_unf};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got s%0d e%0d m%0d o%0d u%0d with empty scoreboard",
                 got.sign, got.ex, got.m, got.ovf, got.unf);
      end else begin
        if (got !== sb[0]) begin
          errors++;
          $display("FAIL result: got s%0d e%0d m%0d o%0d u%0d expected s%0d e%0d m%0d o%0d u%0d",
                   got.sign, got.ex, got.m, got.ovf, got.unf,
                   sb[0].sign, sb[0].ex, sb[0].m, sb[0].ovf, sb[0].unf);
        end
        if (bus.out_ready === 1'b1) void'(sb.pop_front());
      end
    end
  end

  task automatic send(input logic [3:0] me, input logic signed [7:0] s, input res_t e);
    bus.in_valid   = 1'b1;
    bus.in_max_exp = me;
    bus.in_sum     = s;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        sb.push_back(e);
        accepted++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready stayed low for max_exp %0d sum %0d", me, s);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({name, "_pending"}, sb.size(), 0);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_out_valid"}, int'(bus.out_valid), 0);
    chk({name, "_out_sign"},  int'(bus.out_sign), 0);
    chk({name, "_out_exp"},   int'(bus.out_exp), 0);
    chk({name, "_out_mant"},  int'(bus.out_mant), 0);
    chk({name, "_out_ovf"},   int'(bus.out_ovf), 0);
    chk({name, "_out_unf"},   int'(bus.out_unf), 0);
    chk({name, "_in_ready"},  int'(bus.in_ready), 1);
  endtask

  vec_t vecs[12];
  vec_t bp[4];

  initial begin
    vecs[0]  = '{4'd7,  8'sd8,    mk(0, 7,  3'b000, 0, 0)};
    vecs[1]  = '{4'd7,  -8'sd24,  mk(1, 8,  3'b100, 0, 0)};
    vecs[2]  = '{4'd7,  8'sd15,   mk(0, 7,  3'b111, 0, 0)};
    vecs[3]  = '{4'd2,  8'sd1,    mk(0, 0,  0,      0, 1)};
    vecs[4]  = '{4'd5,  8'sd0,    mk(0, 0,  0,      0, 0)};
    vecs[5]  = '{4'd14, 8'sd40,   mk(0, 14, 3'b111, 1, 0)};
    vecs[6]  = '{4'd7,  -8'sd128, mk(1, 11, 3'b000, 0, 0)};
    vecs[7]  = '{4'd3,  8'sd1,    mk(0, 0,  0,      0, 1)};
    vecs[8]  = '{4'd4,  8'sd1,    mk(0, 1,  3'b000, 0, 0)};
    vecs[9]  = '{4'd15, 8'sd8,    mk(0, 14, 3'b111, 1, 0)};
    vecs[10] = '{4'd14, -8'sd8,   mk(1, 14, 3'b000, 0, 0)};
    vecs[11] = '{4'd6,  -8'sd13,  mk(1, 6,  3'b101, 0, 0)};
    bp[0] = '{4'd7, 8'sd8,   mk(0, 7, 3'b000, 0, 0)};
    bp[1] = '{4'd7, -8'sd24, mk(1, 8, 3'b100, 0, 0)};
    bp[2] = '{4'd9, 8'sd3,   mk(0, 7, 3'b100, 0, 0)};
    bp[3] = '{4'd1, -8'sd1,  mk(0, 0, 0,      0, 1)};

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_max_exp = '0;
    bus.in_sum     = '0;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_state("reset");

    foreach (vecs[i]) send(vecs[i].me, vecs[i].sum, vecs[i].res);
    drain("directed");

    // Backpressure: four back-to-back inputs against a stalled output.
    bus.out_ready = 1'b0;
    accepted = 0;
    sender_done = 1'b0;
    fork
      begin
        foreach (bp[i]) send(bp[i].me, bp[i].sum, bp[i].res);
        sender_done = 1'b1;
      end
    join_none
    repeat (5) @(posedge clk);
    #1;
    chk("bp_accepted", accepted, 2);
    chk("bp_in_ready", int'(bus.in_ready), 0);
    chk("bp_out_valid", int'(bus.out_valid), 1);
    chk("bp_held_exp", int'(bus.out_exp), 7);
    chk("bp_held_mant", int'(bus.out_mant), 0);
    bus.out_ready = 1'b1;
    for (int n = 0; n < 100 && !sender_done; n++) @(posedge clk);
    #1;
    chk("bp_sender_done", int'(sender_done), 1);
    drain("bp");
    chk("bp_total_accepted", accepted, 4);

    // Reset with both stages occupied.
    bus.out_ready = 1'b0;
    send(4'd7, 8'sd15, mk(0, 7, 3'b111, 0, 0));
    send(4'd7, -8'sd24, mk(1, 8, 3'b100, 0, 0));
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_state("midreset");
    bus.out_ready = 1'b1;
    send(4'd7, 8'sd15, mk(0, 7, 3'b111, 0, 0));
    drain("post_reset");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
